// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID->EX operand select and registered ALU request with 2-entry skid
// Optional operand forwarding at accept time is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC4 = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [XLEN-1:0] s_rs1,
  input  logic [XLEN-1:0] s_rs2,
  input  logic [XLEN-1:0] s_pc,
  input  logic [XLEN-1:0] s_imm,
  input  logic            s_a_sel,
  input  logic            s_b_sel,
  input  logic [3:0]      s_op,
  input  logic [1:0]      s_wb_sel,
  input  logic [4:0]      s_rd,
  input  logic            s_we,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [4:0]      s_rs1_addr,
  input  logic [4:0]      s_rs2_addr,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            m_valid,
  input  logic            m_ready,
  output logic [67:0]     m_req,
  output logic [1:0]      m_wb_sel,
  output logic [4:0]      m_rd,
  output logic            m_we,
  output logic [XLEN-1:0] m_pc4
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc4;
  } entry_t;

  // Encoding doubles as {skid_valid, m_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e state, state_nxt;
  entry_t in_entry, main_q, skid_q;
  logic   [31:0] rs1_eff, rs2_eff;
  logic   accept, load_main, load_skid, main_from_skid;

`ifdef ALU_ISSUE_FWD_EN
  assign rs1_eff = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == s_rs1_addr) ? fwd_data : s_rs1;
  assign rs2_eff = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == s_rs2_addr) ? fwd_data : s_rs2;
`else
  assign rs1_eff = s_rs1;
  assign rs2_eff = s_rs2;
`endif

  always_comb begin
    in_entry.a      = s_a_sel ? s_pc : rs1_eff;
    in_entry.b      = s_b_sel ? s_imm : rs2_eff;
    in_entry.op     = s_op;
    in_entry.wb_sel = s_wb_sel;
    in_entry.rd     = s_rd;
    in_entry.we     = s_we;
    in_entry.pc4    = s_pc + 32'd4;
  end

  assign accept = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && m_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (m_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (m_ready) begin
          state_nxt      = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Payload may still load during a flush; the cleared valids make it stale.
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  always_comb begin
    m_valid = state[0];
    s_ready = (state != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '{a: 32'h0, b: 32'h0, op: 4'h0, wb_sel: 2'b00, rd: 5'd0, we: 1'b0, pc4: RESET_PC4};
    end else if (load_main) begin
      main_q <= in_entry;
    end else if (main_from_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_entry;
    end
  end

  assign m_req    = {main_q.a, main_q.b, main_q.op};
  assign m_wb_sel = main_q.wb_sel;
  assign m_rd     = main_q.rd;
  assign m_we     = main_q.we;
  assign m_pc4    = main_q.pc4;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
// Forwarding vectors are included when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] rs1, rs2, pc, imm;
    logic        a_sel, b_sel;
    logic [3:0]  op;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp_a, exp_b, exp_pc4;
  } vec_t;

  logic        clk, rst, flush, s_valid, s_ready;
  logic [31:0] s_rs1, s_rs2, s_pc, s_imm;
  logic        s_a_sel, s_b_sel;
  logic [3:0]  s_op;
  logic [1:0]  s_wb_sel;
  logic [4:0]  s_rd;
  logic        s_we;
  logic        m_valid, m_ready;
  logic [67:0] m_req;
  logic [1:0]  m_wb_sel;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [31:0] m_pc4;
`ifdef ALU_ISSUE_FWD_EN
  logic [4:0]  s_rs1_addr, s_rs2_addr, fwd_rd;
  logic        fwd_valid;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;
  vec_t vecs[5];

  alu_issue_stage #(.XLEN(32), .RESET_PC4(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_pc(s_pc), .s_imm(s_imm),
    .s_a_sel(s_a_sel), .s_b_sel(s_b_sel), .s_op(s_op),
    .s_wb_sel(s_wb_sel), .s_rd(s_rd), .s_we(s_we),
`ifdef ALU_ISSUE_FWD_EN
    .s_rs1_addr(s_rs1_addr), .s_rs2_addr(s_rs2_addr),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_req(m_req),
    .m_wb_sel(m_wb_sel), .m_rd(m_rd), .m_we(m_we), .m_pc4(m_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    s_rs1 = v.rs1; s_rs2 = v.rs2; s_pc = v.pc; s_imm = v.imm;
    s_a_sel = v.a_sel; s_b_sel = v.b_sel; s_op = v.op;
    s_wb_sel = v.wb_sel; s_rd = v.rd; s_we = v.we;
  endtask

  function automatic logic [67:0] exp_req(input vec_t v);
    return {v.exp_a, v.exp_b, v.op};
  endfunction

  task automatic check_out(input string name, input vec_t v);
    check({name, ".valid"}, m_valid, 1'b1);
    check({name, ".req"}, m_req, exp_req(v));
    check({name, ".pc4"}, m_pc4, v.exp_pc4);
    check({name, ".side"}, {m_wb_sel, m_rd, m_we}, {v.wb_sel, v.rd, v.we});
  endtask

  initial begin
    //                rs1           rs2           pc            imm           as    bs    op     wb     rd     we    exp_a         exp_b         exp_pc4
    vecs[0] = '{32'h5,        32'h99,       32'h100,      32'h7,        1'b0, 1'b1, 4'h0, 2'd0, 5'd1,  1'b1, 32'h5,        32'h7,        32'h104};
    vecs[1] = '{32'h11,       32'h22,       32'hFFFFFFFC, 32'h1000,     1'b1, 1'b1, 4'h0, 2'd0, 5'd2,  1'b1, 32'hFFFFFFFC, 32'h1000,     32'h0};
    vecs[2] = '{32'h12345678, 32'h0F0F0F0F, 32'h200,      32'h33,       1'b0, 1'b0, 4'h7, 2'd1, 5'd3,  1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h204};
    vecs[3] = '{32'hAAAA,     32'hCAFE,     32'h80000000, 32'h44,       1'b1, 1'b0, 4'hF, 2'd3, 5'd31, 1'b1, 32'h80000000, 32'hCAFE,     32'h80000004};
    vecs[4] = '{32'hFFFFFFFF, 32'h0,        32'hFFFFFFF8, 32'hFFFFF800, 1'b0, 1'b1, 4'hA, 2'd2, 5'd17, 1'b0, 32'hFFFFFFFF, 32'hFFFFF800, 32'hFFFFFFFC};

    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    apply(vecs[4]);
`ifdef ALU_ISSUE_FWD_EN
    s_rs1_addr = 5'd0; s_rs2_addr = 5'd0; fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0;
`endif
    step(); step();
    check("reset.m_valid", m_valid, 1'b0);
    check("reset.s_ready", s_ready, 1'b1);
    check("reset.m_req", m_req, 68'h0);
    check("reset.m_pc4", m_pc4, 32'h0);
    check("reset.side", {m_wb_sel, m_rd, m_we}, 8'h0);

    s_valid = 1'b1;
    step();
    check("reset_override.m_valid", m_valid, 1'b0);
    rst = 1'b0;

    // Streaming with m_ready=1: one entry out per cycle, latency 1
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i]);
      s_valid = 1'b1;
      step();
      check_out($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d.s_ready", i), s_ready, 1'b1);
    end
    s_valid = 1'b0;
    step();
    check("drain.m_valid", m_valid, 1'b0);

    // Backpressure: fill to FULL, hold third entry upstream, drain in order
    m_ready = 1'b0;
    apply(vecs[0]); s_valid = 1'b1;
    step();
    check_out("bp.e1", vecs[0]);
    check("bp.one.s_ready", s_ready, 1'b1);
    apply(vecs[1]);
    step();
    check("bp.full.s_ready", s_ready, 1'b0);
    check_out("bp.full.main", vecs[0]);
    apply(vecs[2]);
    step();
    check("bp.stall.s_ready", s_ready, 1'b0);
    check_out("bp.stall.main", vecs[0]);
    m_ready = 1'b1;
    step();
    check_out("bp.out2", vecs[1]);
    check("bp.out2.s_ready", s_ready, 1'b1);
    step();
    check_out("bp.out3", vecs[2]);
    s_valid = 1'b0;
    step();
    check("bp.empty.m_valid", m_valid, 1'b0);

    // Flush while FULL with upstream still presenting, then flush with an accept
    m_ready = 1'b0;
    apply(vecs[3]); s_valid = 1'b1;
    step();
    apply(vecs[4]);
    step();
    check("fl.full.s_ready", s_ready, 1'b0);
    flush = 1'b1;
    step();
    check("fl.m_valid", m_valid, 1'b0);
    check("fl.s_ready", s_ready, 1'b1);
    step();
    check("fl.accept_dropped.m_valid", m_valid, 1'b0);
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    step();
    check("fl.after.m_valid", m_valid, 1'b0);
    apply(vecs[1]); s_valid = 1'b1;
    step();
    check_out("fl.fresh", vecs[1]);
    s_valid = 1'b0;
    step();
    check("fl.fresh.drain", m_valid, 1'b0);

`ifdef ALU_ISSUE_FWD_EN
    apply(vecs[0]);
    s_rs1 = 32'h0; s_a_sel = 1'b0; s_rs1_addr = 5'd3;
    fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hDEAD;
    s_valid = 1'b1;
    step();
    check("fwd.hit.a", m_req[67:36], 32'hDEAD);
    s_rs1 = 32'h55; s_rs1_addr = 5'd0; fwd_rd = 5'd0;
    step();
    check("fwd.x0.a", m_req[67:36], 32'h55);
    s_valid = 1'b0; fwd_valid = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
